// File: rtl/alu_mdu.sv
// alu_mdu: single-issue ALU with an iterative multiply/divide unit.
// Logic/arith ops finish in one cycle; MULT/MULTU/DIV/DIVU iterate one bit
// per cycle on operand magnitudes, with the sign fix-up in the last step.
// Optional build macro ALU_MDU_EARLY_OUT_EN: multiplies stop as soon as the
// remaining multiplier bits are zero (same results, shorter latency).
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier, rem, quot, divisor;
  logic               neg_lo, neg_hi;

  logic               xfer, is_mul, is_div, b_zero, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, alu_res;
  logic [2*WIDTH-1:0] acc_nxt, prod_fix;
  logic [WIDTH-1:0]   mplier_nxt, rem_nxt, quot_nxt, quot_fix, rem_fix;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic               rem_ge, last_cnt, mul_last, div_last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);
  assign xfer      = in_valid && in_ready;
  assign is_mul    = (op[3:1] == 3'b100);
  assign is_div    = (op[3:1] == 3'b101);
  assign b_zero    = (src_b == '0);
  assign signed_op = ~op[0];
  assign a_neg     = signed_op && src_a[WIDTH-1];
  assign b_neg     = signed_op && src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;

  // Single-cycle ALU result; unused codes (and pass-through codes) return A.
  always_comb begin
    alu_res = src_a;
    case (op)
      4'b0000: alu_res = src_a & src_b;
      4'b0001: alu_res = src_a | src_b;
      4'b0010: alu_res = src_a + src_b;
      4'b0100: alu_res = src_a & ~src_b;
      4'b0101: alu_res = src_a | ~src_b;
      4'b0110: alu_res = src_a - src_b;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1100: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      4'b1101: alu_res = src_a ^ src_b;
      4'b1110: alu_res = ~(src_a | src_b);
      default: alu_res = src_a;
    endcase
  end

  // One shift-add / restoring-divide step plus the signed fix-up of its outcome.
  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mplier_nxt = mplier >> 1;
    rem_sh     = {rem, quot[WIDTH-1]};
    rem_diff   = rem_sh - {1'b0, divisor};
    rem_ge     = ~rem_diff[WIDTH];
    rem_nxt    = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quot_nxt   = {quot[WIDTH-2:0], rem_ge};
    prod_fix   = neg_lo ? -acc_nxt : acc_nxt;
    quot_fix   = neg_lo ? -quot_nxt : quot_nxt;
    rem_fix    = neg_hi ? -rem_nxt : rem_nxt;
    last_cnt   = (cnt == CW'(WIDTH - 1));
    div_last   = last_cnt;
`ifdef ALU_MDU_EARLY_OUT_EN
    mul_last   = last_cnt || (mplier_nxt == '0);
`else
    mul_last   = last_cnt;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection; a zero divisor short-circuits straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer) begin
        if (is_mul)                 state_nxt = MUL;
        else if (is_div && !b_zero) state_nxt = DIV;
        else                        state_nxt = DONE;
      end
      MUL:  if (mul_last)  state_nxt = DONE;
      DIV:  if (div_last)  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration registers and the held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem         <= '0;
      quot        <= '0;
      divisor     <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          cnt         <= '0;
          div_by_zero <= 1'b0;
          if (is_mul) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg_lo <= a_neg ^ b_neg;
          end else if (is_div && !b_zero) begin
            rem     <= '0;
            quot    <= a_mag;
            divisor <= b_mag;
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= a_neg;
          end else if (is_div) begin
            result      <= '1;
            result_hi   <= src_a;
            zero        <= 1'b0;
            div_by_zero <= 1'b1;
          end else begin
            result    <= alu_res;
            result_hi <= '0;
            zero      <= (alu_res == '0);
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier_nxt;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            result    <= prod_fix[WIDTH-1:0];
            result_hi <= prod_fix[2*WIDTH-1:WIDTH];
            zero      <= (prod_fix[WIDTH-1:0] == '0);
          end
        end
        DIV: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 1'b1;
          if (div_last) begin
            result    <= quot_fix;
            result_hi <= rem_fix;
            zero      <= (quot_fix == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and randomized bench for alu_mdu (WIDTH = 32).
// A plain-arithmetic model predicts every result and its latency; one
// compare process checks the DUT against the pending prediction each cycle.
module tb_alu_mdu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          zero;
  logic          div_by_zero;
  logic          busy;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc   = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    longint      due;
  } exp_t;

  exp_t q[$];

  alu_mdu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .zero       (zero),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count rising edges so latencies can be expressed in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Number of multiply iterations for a given multiplier magnitude.
  function automatic int mulIters(input logic [31:0] m);
    int n;
`ifdef ALU_MDU_EARLY_OUT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`else
    n = 32;
`endif
    return n;
  endfunction

  // Reference behaviour from the operation rules, using 64-bit arithmetic.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] lo, output logic [31:0] hi,
                                output logic dbz, output int iters);
    longint      sa, sb, qq, rr;
    logic [63:0] p;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo = a; hi = '0; dbz = 1'b0; iters = 0;
    case (o)
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0010: lo = 32'(sa + sb);
      4'b0100: lo = a & ~b;
      4'b0101: lo = a | ~b;
      4'b0110: lo = 32'(sa - sb);
      4'b0111: lo = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: lo = (a < b) ? 32'd1 : 32'd0;
      4'b1101: lo = a ^ b;
      4'b1110: lo = ~(a | b);
      4'b1000: begin
        p = 64'(sa * sb);
        lo = p[31:0]; hi = p[63:32];
        iters = mulIters((sb < 0) ? 32'(-sb) : b);
      end
      4'b1001: begin
        p = {32'b0, a} * {32'b0, b};
        lo = p[31:0]; hi = p[63:32];
        iters = mulIters(b);
      end
      4'b1010, 4'b1011: begin
        if (b == 32'd0) begin
          lo = '1; hi = a; dbz = 1'b1;
        end else begin
          if (o == 4'b1010) begin
            qq = sa / sb; rr = sa % sb;
          end else begin
            qq = longint'({32'b0, a}) / longint'({32'b0, b});
            rr = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          qv = 64'(qq); rv = 64'(rr);
          lo = qv[31:0]; hi = rv[31:0];
          iters = 32;
        end
      end
      default: lo = a;
    endcase
  endfunction

  // Every cycle out of reset: outputs must match the oldest pending prediction.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else if (q.size() == 0) begin
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_in_ready", in_ready, 1);
    end else if (cyc < q[0].due) begin
      checkOutput("pend_out_valid", out_valid, 0);
      checkOutput("pend_in_ready", in_ready, 0);
      checkOutput("pend_busy", busy, 1);
    end else begin
      checkOutput("out_valid", out_valid, 1);
      checkOutput("result", result, q[0].lo);
      checkOutput("result_hi", result_hi, q[0].hi);
      checkOutput("zero", zero, (q[0].lo == 32'd0));
      checkOutput("div_by_zero", div_by_zero, q[0].dbz);
      checkOutput("done_in_ready", in_ready, 0);
      checkOutput("done_busy", busy, 0);
      if (out_valid && out_ready) void'(q.pop_front());
    end
  end

  // Issue one operation once in_ready is seen, then record its prediction.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   it;
    int   n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("[TB] FAIL issue_wait: got in_ready=0, expected 1 within 100 cycles");
      return;
    end
    in_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(o, a, b, e.lo, e.hi, e.dbz, it);
    e.due = cyc + it;
    q.push_back(e);
  endtask

  // Drain the pending result; optionally jitter out_ready and inject ignored requests.
  task automatic waitDone(input bit rnd);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = out_ready ? 1'b0 : 1'($urandom_range(0, 1));
        op        = 4'($urandom);
        src_a     = $urandom;
        src_b     = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("[TB] FAIL wait_done: got result still pending, expected handshake within 200 cycles");
      q.delete();
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkModel(input string name, input logic [3:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                            input logic edbz);
    logic [31:0] lo, hi;
    logic        dbz;
    int          it;
    model(o, a, b, lo, hi, dbz, it);
    checkOutput({name, "_lo"}, lo, elo);
    checkOutput({name, "_hi"}, hi, ehi);
    checkOutput({name, "_dbz"}, dbz, edbz);
  endtask

  initial begin
    logic [31:0] mlo, mhi;
    logic        mdbz;
    int          mit, exp_it;

    $display("[TB] alu_mdu bench start");

    // Hand-computed values pinning the reference model.
    checkModel("pin_add", 4'b0010, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'd0, 1'b0);
    checkModel("pin_mult", 4'b1000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    checkModel("pin_multu", 4'b1001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1, 1'b0);
    checkModel("pin_div", 4'b1010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    checkModel("pin_divu", 4'b1011, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    checkModel("pin_divmin", 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    checkModel("pin_div0", 4'b1011, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1);
    checkModel("pin_slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0);
    checkModel("pin_sltu", 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
`ifdef ALU_MDU_EARLY_OUT_EN
    exp_it = 2;
`else
    exp_it = 32;
`endif
    model(4'b1001, 32'd7, 32'd3, mlo, mhi, mdbz, mit);
    checkOutput("pin_iters_7x3", mit, exp_it);

    // Power-on reset state.
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_zero", zero, 1);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Reset in the middle of a multiply, then a simple ADD.
    applyStimulus(4'b1000, 32'hFFFF_FFFD, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", out_valid, 0);
    checkOutput("mrst_in_ready", in_ready, 1);
    checkOutput("mrst_result", result, 0);
    checkOutput("mrst_result_hi", result_hi, 0);
    checkOutput("mrst_zero", zero, 1);
    checkOutput("mrst_dbz", div_by_zero, 0);
    checkOutput("mrst_busy", busy, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1);
    applyStimulus(4'b0010, 32'd5, 32'hFFFF_FFFD);
    waitDone(1'b0);

    // Directed multiply / divide / divide-by-zero cases.
    applyStimulus(4'b1000, 32'hFFFF_FFFD, 32'd7);          waitDone(1'b0);
    applyStimulus(4'b1001, 32'hFFFF_FFFF, 32'd2);          waitDone(1'b0);
    applyStimulus(4'b1010, 32'hFFFF_FFF9, 32'd2);          waitDone(1'b0);
    applyStimulus(4'b1011, 32'd100, 32'd7);                waitDone(1'b0);
    applyStimulus(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);  waitDone(1'b0);
    applyStimulus(4'b1011, 32'd9, 32'd0);                  waitDone(1'b0);
    applyStimulus(4'b0110, 32'd4, 32'd4);                  waitDone(1'b0);

    // Compares, with the result held under backpressure and stray requests.
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'd1);          waitDone(1'b0);
    out_ready = 1'b0;
    applyStimulus(4'b1100, 32'hFFFF_FFFF, 32'd1);
    repeat (5) begin
      in_valid = 1'($urandom_range(0, 1));
      op = 4'($urandom); src_a = $urandom; src_b = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    waitDone(1'b0);

    // Multiplier early-out latency cases.
    applyStimulus(4'b1001, 32'd7, 32'd3);                  waitDone(1'b0);
    applyStimulus(4'b1001, 32'd5, 32'd0);                  waitDone(1'b0);

    // Randomized operations with jittered out_ready.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'($urandom), pickOperand(), pickOperand());
      waitDone(1'b1);
    end
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
